// File: rtl/sha_cu_pkg.sv
// Shared types and constants for the SHA-256 control unit.
//   sha_cu_state_t : FSM state encoding (IDLE/LOAD/RUN/DONE)
//   sha_cu_out_t   : bundle of the three control outputs
//   decode_outputs : Moore output decode for a given state
package sha_cu_pkg;

    localparam int SHA_ROUNDS = 64;
    localparam int SHA_CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } sha_cu_state_t;

    typedef struct packed {
        logic cnt_en;
        logic valid;
        logic sel;
    } sha_cu_out_t;

    // Output values (cnt_en / valid / sel) owned by each state.
    function automatic sha_cu_out_t decode_outputs(input sha_cu_state_t st);
        sha_cu_out_t o;
        case (st)
            IDLE:    o = '{cnt_en: 1'b0, valid: 1'b0, sel: 1'b0};
            LOAD:    o = '{cnt_en: 1'b1, valid: 1'b0, sel: 1'b0};
            RUN:     o = '{cnt_en: 1'b1, valid: 1'b0, sel: 1'b1};
            DONE:    o = '{cnt_en: 1'b0, valid: 1'b1, sel: 1'b1};
            default: o = '{cnt_en: 1'b0, valid: 1'b0, sel: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sha_round_cnt.sv
// Internal round counter, only built with SHA_CU_INT_CNT_EN defined.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   clr   - synchronous clear (held while the control unit is idle)
//   en    - advance one round
//   count - current round number, 0 .. ROUNDS-1
//   last  - high while count == ROUNDS-1
`ifdef SHA_CU_INT_CNT_EN
module sha_round_cnt #(
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    // Round count register; wraps to zero after the last round.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= {CNT_W{1'b0}};
        end else if (clr) begin
            count <= {CNT_W{1'b0}};
        end else if (en) begin
            if (last) begin
                count <= {CNT_W{1'b0}};
            end else begin
                count <= count + CNT_W'(1);
            end
        end else begin
            count <= count;
        end
    end

    assign last = (count == CNT_W'(ROUNDS - 1));

endmodule
`endif

// File: rtl/sha_cu.sv
// SHA-256 compression control unit (Moore FSM).
// Sequences one compression: LOAD (initial values into the datapath),
// RUN (round feedback) until the last-round flag, then DONE pulses o_valid.
// Ports:
//   usr_clk    - clock
//   usr_reset  - synchronous active-high reset
//   i_start    - start request, only honoured in IDLE
//   i_cnt_flag - last-round flag from the external round counter
//   o_cnt_en   - round-counter enable (LOAD, RUN)
//   o_valid    - one-cycle hash-valid pulse (DONE)
//   sel_1      - datapath mux: 0 = initial load, 1 = round feedback
//   o_round    - internal round count (only with SHA_CU_INT_CNT_EN)
// Build option SHA_CU_INT_CNT_EN: use an internal round counter instead of
// i_cnt_flag (which is then ignored) and expose it on o_round.
module sha_cu
    import sha_cu_pkg::*;
#(
    parameter int ROUNDS = SHA_ROUNDS
) (
    input  logic usr_clk,
    input  logic usr_reset,
    input  logic i_start,
    input  logic i_cnt_flag,
`ifdef SHA_CU_INT_CNT_EN
    output logic [$clog2(ROUNDS)-1:0] o_round,
`endif
    output logic o_cnt_en,
    output logic o_valid,
    output logic sel_1
);

    sha_cu_state_t state_r;
    sha_cu_state_t next_state_s;
    sha_cu_out_t   out_next_s;
    logic          last_flag_s;

`ifdef SHA_CU_INT_CNT_EN
    localparam int CNT_W = $clog2(ROUNDS);

    logic [CNT_W-1:0] round_s;
    logic             int_last_s;
    logic             cnt_clr_s;
    logic             unused_cnt_flag_s;

    assign cnt_clr_s         = (state_r == IDLE);
    assign unused_cnt_flag_s = i_cnt_flag;

    sha_round_cnt #(
        .ROUNDS (ROUNDS),
        .CNT_W  (CNT_W)
    ) u_round_cnt (
        .clk   (usr_clk),
        .rst   (usr_reset),
        .clr   (cnt_clr_s),
        .en    (o_cnt_en),
        .count (round_s),
        .last  (int_last_s)
    );

    assign o_round     = round_s;
    assign last_flag_s = int_last_s;
`else
    localparam int unused_rounds = ROUNDS;

    assign last_flag_s = i_cnt_flag;
`endif

    // Next-state logic plus output decode of the state being entered.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: next_state_s = RUN;
            RUN: begin
                if (last_flag_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
        out_next_s = decode_outputs(next_state_s);
    end

    // State register; outputs are registered alongside it from the decode of
    // the next state, so they always equal decode_outputs(state_r).
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            state_r  <= IDLE;
            o_cnt_en <= 1'b0;
            o_valid  <= 1'b0;
            sel_1    <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            o_cnt_en <= out_next_s.cnt_en;
            o_valid  <= out_next_s.valid;
            sel_1    <= out_next_s.sel;
        end
    end

endmodule

// File: tb/tb_sha_cu.sv
// Self-checking bench for sha_cu: a directed vector table, hand-written
// sequences for full hashes / mid-run reset / back-to-back starts, and a
// randomized run checked against a behavioural model of the hash timeline.
module tb_sha_cu;

    localparam int ROUNDS = 64;

    logic usr_clk = 1'b0;
    logic usr_reset;
    logic i_start;
    logic i_cnt_flag;
    logic o_cnt_en;
    logic o_valid;
    logic sel_1;
`ifdef SHA_CU_INT_CNT_EN
    logic [5:0] o_round;
`endif

    always #5 usr_clk = ~usr_clk;

    sha_cu #(.ROUNDS(ROUNDS)) dut (
        .usr_clk    (usr_clk),
        .usr_reset  (usr_reset),
        .i_start    (i_start),
        .i_cnt_flag (i_cnt_flag),
`ifdef SHA_CU_INT_CNT_EN
        .o_round    (o_round),
`endif
        .o_cnt_en   (o_cnt_en),
        .o_valid    (o_valid),
        .sel_1      (sel_1)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: a hash is "busy" from its start edge; cycles counts
    // cycles into the hash (1 = load cycle); finish marks the valid cycle.
    bit m_busy   = 1'b0;
    bit m_finish = 1'b0;
    int m_cyc    = 0;
    int ext_cnt  = 0;   // external round counter, cleared while not enabled
    int cyc_no   = 0;
    int valid_seen = 0;
    int en_seen    = 0;
    int last_valid_cyc = 0;
    int pulse_q[$];

    function automatic logic m_en();
        return m_busy && !m_finish;
    endfunction

    function automatic logic m_sel();
        return m_finish || (m_busy && (m_cyc >= 2));
    endfunction

    function automatic logic ext_flag();
        return (ext_cnt == ROUNDS - 1);
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at negedge.
    task automatic tick(input logic rst, input logic st, input logic fl);
        logic eff_flag;
        logic en_prev;
        usr_reset  = rst;
        i_start    = st;
        i_cnt_flag = fl;
        @(posedge usr_clk);
`ifdef SHA_CU_INT_CNT_EN
        eff_flag = ext_flag();
`else
        eff_flag = fl;
`endif
        en_prev = m_en();
        if (rst) begin
            m_busy = 1'b0; m_finish = 1'b0; m_cyc = 0; ext_cnt = 0;
        end else begin
            ext_cnt = en_prev ? ext_cnt + 1 : 0;
            if (m_finish) begin
                m_busy = 1'b0; m_finish = 1'b0;
            end else if (!m_busy) begin
                if (st) begin
                    m_busy = 1'b1; m_cyc = 1;
                end
            end else begin
                if ((m_cyc >= 2) && eff_flag) m_finish = 1'b1;
                m_cyc++;
            end
        end
        cyc_no++;
        @(negedge usr_clk);
        check_bit("o_cnt_en", o_cnt_en, m_en());
        check_bit("o_valid", o_valid, m_finish);
        check_bit("sel_1", sel_1, m_sel());
`ifdef SHA_CU_INT_CNT_EN
        if (m_en()) check_int("o_round", int'(o_round), ext_cnt);
`endif
        if (o_valid === 1'b1) begin
            valid_seen++;
            last_valid_cyc = cyc_no;
            pulse_q.push_back(cyc_no);
        end
        if (o_cnt_en === 1'b1) en_seen++;
    endtask

    // Full hash from IDLE with the external counter driving i_cnt_flag.
    task automatic run_hash(input string tag);
        int n;
        int start_cyc;
        valid_seen = 0;
        en_seen    = 0;
        tick(1'b0, 1'b1, 1'b0);
        start_cyc = cyc_no;
        n = 0;
        while (m_busy && n < 200) begin
            tick(1'b0, 1'b0, ext_flag());
            n++;
        end
        check_bit({tag, "_timeout"}, (n < 200), 1'b1);
        check_int({tag, "_en_cycles"}, en_seen, ROUNDS);
        check_int({tag, "_valid_pulses"}, valid_seen, 1);
        check_int({tag, "_valid_cycle"}, last_valid_cyc - start_cyc + 1, ROUNDS + 1);
    endtask

    typedef struct {
        string name;
        logic  rst, st, fl;
        logic  en, vl, sl;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n;
        usr_reset  = 1'b1;
        i_start    = 1'b0;
        i_cnt_flag = 1'b0;
        @(negedge usr_clk);

        // Reset with start held, spurious flags in IDLE and LOAD.
        vecs.push_back('{"rst_a",     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"rst_b",     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"idle_flag", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"load",      1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"run",       1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
`ifdef SHA_CU_INT_CNT_EN
        vecs.push_back('{"rst_c",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
`else
        vecs.push_back('{"done",      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"idle",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
`endif
        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].st, vecs[i].fl);
            check_bit({"tbl_", vecs[i].name, "_en"}, o_cnt_en, vecs[i].en);
            check_bit({"tbl_", vecs[i].name, "_valid"}, o_valid, vecs[i].vl);
            check_bit({"tbl_", vecs[i].name, "_sel"}, sel_1, vecs[i].sl);
        end

        // Nominal hash.
        run_hash("nominal");

        // Reset at round 30, then a fresh hash.
        tick(1'b0, 1'b1, 1'b0);
        n = 0;
        while (ext_cnt < 30 && n < 100) begin
            tick(1'b0, 1'b0, ext_flag());
            n++;
        end
        check_int("midrst_round", ext_cnt, 30);
        valid_seen = 0;
        tick(1'b1, 1'b0, 1'b0);
        check_bit("midrst_en", o_cnt_en, 1'b0);
        check_bit("midrst_sel", sel_1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check_int("midrst_no_valid", valid_seen, 0);
        run_hash("restart");

        // Back-to-back: start held high.
        pulse_q.delete();
        for (int i = 0; i < 200; i++) tick(1'b0, 1'b1, ext_flag());
        check_int("b2b_pulses", pulse_q.size(), 3);
        if (pulse_q.size() >= 3) begin
            check_int("b2b_period1", pulse_q[1] - pulse_q[0], ROUNDS + 2);
            check_int("b2b_period2", pulse_q[2] - pulse_q[1], ROUNDS + 2);
        end
        tick(1'b1, 1'b0, 1'b0);

        // Randomized starts, flags and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) == 0),
                 ext_flag() | ($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha_cu.md
Name:
sha_cu

Overview:
- Control unit (FSM) for the SHA-256 hashing datapath.
- Sequences one 64-round compression: loads initial data, enables the external round counter, and switches the datapath mux to feedback.
- Pulses o_valid when the counter reports the last round.
- Sits between the top-level start request and the round counter / datapath mux.

Parameters:
- ROUNDS, 64, rounds per hash; used only by the internal counter option (range 2..256).

Ports:
- usr_clk, in, 1, system clock; all state changes on its rising edge.
- usr_reset, in, 1, synchronous active-high reset.
- i_start, in, 1, request to begin a hash; sampled only in IDLE.
- i_cnt_flag, in, 1, last-round flag from the external round counter (high while counter = ROUNDS-1).
- o_cnt_en, out, 1, round-counter enable.
- o_valid, out, 1, one-cycle pulse: hash result valid.
- sel_1, out, 1, datapath mux select: 0 = initial hash/message load, 1 = round feedback.

Behaviour:
- Moore FSM; state register clocked on usr_clk; outputs decoded from state only (no input-to-output combinational path).
- Reset: usr_reset=1 at a rising edge forces IDLE. Applies in any state, including mid-hash; no partial result is flagged.
- Reset output values: o_cnt_en=0, o_valid=0, sel_1=0.
- States, 2-bit encoding, declared as enum in package:
  - IDLE=00
  - LOAD=01
  - RUN=10
  - DONE=11
- Outputs (o_cnt_en / o_valid / sel_1) by state:
  - IDLE: 0/0/0
  - LOAD: 1/0/0
  - RUN: 1/0/1
  - DONE: 0/1/1
- Transitions:
  - IDLE: i_start=1 -> LOAD; else stay.
  - LOAD: unconditionally -> RUN after exactly 1 cycle; i_cnt_flag ignored.
  - RUN: i_cnt_flag=1 -> DONE; else stay.
  - DONE: unconditionally -> IDLE after 1 cycle.
- Latency: i_start sampled at edge k gives LOAD during cycle k+1 and RUN from k+2. o_valid is high for exactly the cycle after the edge where RUN samples i_cnt_flag=1.
- A full hash has o_cnt_en high for ROUNDS cycles (LOAD + ROUNDS-1 RUN cycles) when the external counter is cleared at start.
- i_start outside IDLE is ignored; no queuing.
- i_start held high continuously: a new hash begins in the cycle after DONE (IDLE lasts one cycle).
- i_cnt_flag in IDLE, LOAD or DONE: ignored.
- Unused or illegal encodings are unreachable; the default branch returns to IDLE.

Optional Feature:
- Macro: SHA_CU_INT_CNT_EN.
- Defined:
  - Adds an internal counter of $clog2(ROUNDS) bits.
  - Counter cleared in IDLE; increments while o_cnt_en=1.
  - Internal last-round flag = (count == ROUNDS-1), replacing i_cnt_flag.
  - i_cnt_flag port remains but is ignored.
  - Adds output port o_round (width $clog2(ROUNDS)) carrying the count.
- Undefined: no counter, no o_round; i_cnt_flag drives the RUN->DONE transition.

Decomposition:
- Package sha_cu_pkg holds:
  - state enum type sha_cu_state_t;
  - localparam SHA_ROUNDS=64;
  - localparam SHA_CNT_W=6.
- No sub-module for the base FSM.
- Under the macro, the round counter is a natural sub-module: sha_round_cnt (clk, sync reset, clear, enable, count, last flag).

Test Plan:
- Reset: hold usr_reset=1 for 2 cycles with i_start=1 -> o_cnt_en=0, o_valid=0, sel_1=0 throughout; no LOAD.
- Nominal hash:
  - Stimulus: release reset; pulse i_start for 1 cycle; a model counter asserts i_cnt_flag at count 63.
  - Required: 1 LOAD cycle (sel_1=0, o_cnt_en=1), then RUN with sel_1=1.
  - o_cnt_en high for exactly 64 cycles; o_valid high exactly 1 cycle; back to IDLE with outputs 0/0/0.
- Spurious flags: i_cnt_flag=1 in IDLE and during the LOAD cycle -> no o_valid; LOAD still goes to RUN.
- Reset mid-run: assert usr_reset at round 30 -> next cycle outputs 0/0/0; no o_valid; a fresh i_start restarts from LOAD.
- Back-to-back: i_start held high -> sequence LOAD, RUN×63, DONE, IDLE(1), LOAD repeats; o_valid pulses every 66 cycles.
- SHA_CU_INT_CNT_EN defined, i_cnt_flag tied 0: o_round counts 0..63; o_valid at cycle 65 after the start edge.
